relu6_fp16: RTL and testbench
=============================

Name: relu6_fp16

Overview:
Registered ReLU6 activation for IEEE-754 binary16 (FP16) samples, one sample per clock. Computes out = min(max(x, 0), 6.0) with fixed handling of special values. Sits between an FP16 MAC/accumulator stage and the next layer's input buffer in the pipelined DNN datapath.

Parameters:
CLIP_VALUE, 16'h4600, upper clamp bound as an FP16 bit pattern (6.0). Must be positive and finite.
PIPE_STAGES, 1, number of output register stages (legal values 1 or 2). Total latency equals PIPE_STAGES.

Ports:
clk  input  1  system clock; all state updates on the rising edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  in_data is valid this cycle
in_data  input  16  FP16 operand {sign, exp[4:0], mant[9:0]}
out_valid  output  1  out_data is valid; in_valid delayed by PIPE_STAGES
out_data  output  16  FP16 ReLU6 result
out_clamp_lo  output  1  result was forced to 0 (negative input or NaN)
out_clamp_hi  output  1  result was forced to CLIP_VALUE
out_nan  output  1  input was NaN

Behaviour:
- One clock and one synchronous active-high reset (clk, rst). No other clocks or asynchronous logic.
- Reset: while rst=1 at a clock edge, all pipeline registers clear. out_valid=0, out_data=16'h0000, all flags=0. Data in flight during reset is discarded.
- No backpressure. Every valid input produces exactly one valid output PIPE_STAGES cycles later. Back-to-back inputs are accepted at full rate.
- Data and flag registers load every cycle regardless of in_valid. Downstream must qualify them with out_valid.
- Classification of in_data, in priority order:
  1. NaN (exp=5'h1F, mant!=0, either sign): result 16'h0000, out_nan=1, out_clamp_lo=1.
  2. sign=1, covering -0, negative subnormals, negative normals and -Inf: result 16'h0000, out_clamp_lo=1.
  3. Positive and in_data[14:0] > CLIP_VALUE[14:0] as an unsigned compare, including +Inf: result CLIP_VALUE, out_clamp_hi=1.
  4. Otherwise (+0, positive subnormals, 0 < x <= 6.0): pass in_data through unchanged, no flags set.
- The unsigned compare in step 3 is valid because the ordering of positive FP16 values matches the ordering of their bit patterns. No FP arithmetic unit is used.
- An input of exactly 6.0 (16'h4600) passes through with out_clamp_hi=0.
- -0 (16'h8000) produces +0 (16'h0000). The result is never negative zero.
- At most one of out_clamp_lo and out_clamp_hi is set. out_nan implies out_clamp_lo.
- Stage 1 registers the result and flags. When PIPE_STAGES=2, stage 2 is a plain retiming register.

Decomposition:
- Shared package fp16_pkg holds:
  - FP16 field widths (EXP_W=5, MAN_W=10) and the exponent all-ones constant;
  - constants FP16_ZERO=16'h0000, FP16_ONE=16'h3C00, FP16_SIX=16'h4600, FP16_POS_INF=16'h7C00;
  - a packed struct typedef for {sign, exp, mant};
  - helper functions is_nan() and is_neg().
- One combinational sub-module, fp16_relu6_core, does classification and result selection. The top level adds the valid pipeline and registers.

Test Plan:
- Reset: hold rst=1 for 3 cycles with in_valid=1 and in_data=16'h4200 -> out_valid=0, out_data=16'h0000 and all flags 0 throughout. The first output appears PIPE_STAGES cycles after rst drops.
- Sign/zero: stream 16'hBC00 (-1.0), 16'h0000, 16'h8000 (-0), 16'hFC00 (-Inf) back-to-back -> outputs 0000, 0000, 0000, 0000. out_clamp_lo is 1,0,1,1 respectively.
- Pass-through: 16'h3C00 (1.0), 16'h4200 (3.0), 16'h4600 (6.0), 16'h0001 (smallest subnormal) -> outputs equal inputs, no flags, each arriving exactly PIPE_STAGES cycles after its input.
- Upper clamp: 16'h4601 (6.0039), 16'h4700 (7.0), 16'h7BFF (max normal), 16'h7C00 (+Inf) -> each output 16'h4600 with out_clamp_hi=1.
- NaN: 16'h7E00 and 16'hFE01 -> out_data=16'h0000, out_nan=1, out_clamp_lo=1.
- Valid gaps: toggle in_valid randomly over 200 random FP16 inputs -> out_valid mirrors in_valid delayed by PIPE_STAGES. Every valid output matches a reference model. Run with PIPE_STAGES=1 and PIPE_STAGES=2.

Source files
------------

// File: rtl/fp16_pkg.sv
// FP16 field layout, constants and classification helpers
// shared by the ReLU6 activation datapath.
package fp16_pkg;

    localparam int EXP_W  = 5;
    localparam int MAN_W  = 10;
    localparam int FP16_W = 1 + EXP_W + MAN_W;

    localparam logic [EXP_W-1:0] EXP_ONES = '1;

    localparam logic [FP16_W-1:0] FP16_ZERO    = 16'h0000;
    localparam logic [FP16_W-1:0] FP16_ONE     = 16'h3C00;
    localparam logic [FP16_W-1:0] FP16_SIX     = 16'h4600;
    localparam logic [FP16_W-1:0] FP16_POS_INF = 16'h7C00;

    typedef struct packed {
        logic             sign;
        logic [EXP_W-1:0] exp;
        logic [MAN_W-1:0] mant;
    } fp16_t;

    typedef struct packed {
        logic              valid;
        logic [FP16_W-1:0] data;
        logic              clamp_lo;
        logic              clamp_hi;
        logic              nan;
    } relu6_out_t;

    function automatic logic is_nan(input fp16_t x);
        return (x.exp == EXP_ONES) && (x.mant != '0);
    endfunction

    // Negative ordered value: -0, subnormals, normals, -Inf (NaN excluded)
    function automatic logic is_neg(input fp16_t x);
        return x.sign && !is_nan(x);
    endfunction

endpackage

// File: rtl/fp16_relu6_core.sv
// Combinational ReLU6 classification and result select.
// Positive FP16 bit patterns order like their values, so an integer compare suffices.
module fp16_relu6_core
    import fp16_pkg::*;
#(
    parameter logic [15:0] CLIP_VALUE = FP16_SIX
) (
    input  logic [15:0] x,
    output logic [15:0] y,
    output logic        clamp_lo,
    output logic        clamp_hi,
    output logic        nan
);

    fp16_t f;
    logic  c_nan;
    logic  c_neg;
    logic  c_hi;

    assign f     = x;
    assign c_nan = is_nan(f);
    assign c_neg = is_neg(f);
    assign c_hi  = !f.sign && !c_nan && (x[14:0] > CLIP_VALUE[14:0]);

    always_comb begin
        y        = x;
        clamp_lo = 1'b0;
        clamp_hi = 1'b0;
        nan      = 1'b0;
        unique case (1'b1)
            c_nan: begin
                y        = FP16_ZERO;
                clamp_lo = 1'b1;
                nan      = 1'b1;
            end
            c_neg: begin
                y        = FP16_ZERO;
                clamp_lo = 1'b1;
            end
            c_hi: begin
                y        = CLIP_VALUE;
                clamp_hi = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/relu6_fp16.sv
// Registered FP16 ReLU6, one sample per clock, latency PIPE_STAGES (1 or 2).
// Data and flag registers load every cycle; consumers qualify with out_valid.
module relu6_fp16
    import fp16_pkg::*;
#(
    parameter logic [15:0] CLIP_VALUE  = FP16_SIX,
    parameter int          PIPE_STAGES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    input  logic [15:0] in_data,
    output logic        out_valid,
    output logic [15:0] out_data,
    output logic        out_clamp_lo,
    output logic        out_clamp_hi,
    output logic        out_nan
);

    logic       [15:0] y;
    logic              lo;
    logic              hi;
    logic              nn;
    relu6_out_t        s1;
    relu6_out_t        s_out;

    fp16_relu6_core #(
        .CLIP_VALUE(CLIP_VALUE)
    ) u_core (
        .x       (in_data),
        .y       (y),
        .clamp_lo(lo),
        .clamp_hi(hi),
        .nan     (nn)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= '0;
        end else begin
            s1.valid    <= in_valid;
            s1.data     <= y;
            s1.clamp_lo <= lo;
            s1.clamp_hi <= hi;
            s1.nan      <= nn;
        end
    end

    generate
        if (PIPE_STAGES == 2) begin : g_stage2
            relu6_out_t s2;
            always_ff @(posedge clk) begin
                if (rst) s2 <= '0;
                else     s2 <= s1;
            end
            assign s_out = s2;
        end else begin : g_stage1
            assign s_out = s1;
        end
    endgenerate

    assign out_valid    = s_out.valid;
    assign out_data     = s_out.data;
    assign out_clamp_lo = s_out.clamp_lo;
    assign out_clamp_hi = s_out.clamp_hi;
    assign out_nan      = s_out.nan;

endmodule

// File: tb/tb_relu6_fp16.sv
// Directed and random bench for relu6_fp16 at PIPE_STAGES 1 and 2.
// Expected records travel through bench-side delay lines matching each latency.
module tb_relu6_fp16;

    typedef struct packed {
        logic        v;
        logic [15:0] d;
        logic        lo;
        logic        hi;
        logic        nan;
    } exp_t;

    typedef struct packed {
        logic [15:0] din;
        logic [15:0] dout;
        logic        lo;
        logic        hi;
        logic        nan;
    } vec_t;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_data;

    logic        v1, lo1, hi1, nan1;
    logic [15:0] d1;
    logic        v2, lo2, hi2, nan2;
    logic [15:0] d2;

    int    checks;
    int    errors;
    bit    chk_en;
    string phase;

    exp_t cur_exp;
    exp_t e1;
    exp_t e2a;
    exp_t e2b;

    relu6_fp16 #(.CLIP_VALUE(16'h4600), .PIPE_STAGES(1)) u_p1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(v1), .out_data(d1), .out_clamp_lo(lo1),
        .out_clamp_hi(hi1), .out_nan(nan1)
    );

    relu6_fp16 #(.CLIP_VALUE(16'h4600), .PIPE_STAGES(2)) u_p2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .out_valid(v2), .out_data(d2), .out_clamp_lo(lo2),
        .out_clamp_hi(hi2), .out_nan(nan2)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Expected-value delay lines; cleared by reset like the DUT registers
    always @(posedge clk) begin
        if (rst) begin
            e1  <= '0;
            e2a <= '0;
            e2b <= '0;
        end else begin
            e1  <= cur_exp;
            e2a <= cur_exp;
            e2b <= e2a;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            exp_t a1;
            exp_t a2;
            a1 = '{v1, d1, lo1, hi1, nan1};
            a2 = '{v2, d2, lo2, hi2, nan2};
            checks++;
            if (a1 !== e1) begin
                errors++;
                $display("FAIL %s pipe1 @%0t: got v=%b d=%h lo=%b hi=%b nan=%b, expected v=%b d=%h lo=%b hi=%b nan=%b",
                         phase, $time, a1.v, a1.d, a1.lo, a1.hi, a1.nan,
                         e1.v, e1.d, e1.lo, e1.hi, e1.nan);
            end
            checks++;
            if (a2 !== e2b) begin
                errors++;
                $display("FAIL %s pipe2 @%0t: got v=%b d=%h lo=%b hi=%b nan=%b, expected v=%b d=%h lo=%b hi=%b nan=%b",
                         phase, $time, a2.v, a2.d, a2.lo, a2.hi, a2.nan,
                         e2b.v, e2b.d, e2b.lo, e2b.hi, e2b.nan);
            end
        end
    end

    function automatic exp_t ref_model(input logic v, input logic [15:0] x);
        exp_t       r;
        logic [4:0] e;
        logic [9:0] m;
        e = x[14:10];
        m = x[9:0];
        r = '0;
        r.v = v;
        if (e == 5'd31 && m != 10'd0) begin
            r.lo  = 1'b1;
            r.nan = 1'b1;
        end else if (x[15]) begin
            r.lo = 1'b1;
        end else if (e > 5'd17 || (e == 5'd17 && m > 10'h200)) begin
            r.d  = 16'h4600;
            r.hi = 1'b1;
        end else begin
            r.d = x;
        end
        return r;
    endfunction

    task automatic drive(input logic v, input logic [15:0] d, input exp_t e);
        in_valid = v;
        in_data  = d;
        cur_exp  = e;
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[18];

    initial begin
        exp_t e;

        vecs[0]  = '{16'hBC00, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h8000, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'hFC00, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[4]  = '{16'h3C00, 16'h3C00, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h4200, 16'h4200, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h4600, 16'h4600, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'h0001, 16'h0001, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'h4601, 16'h4600, 1'b0, 1'b1, 1'b0};
        vecs[9]  = '{16'h4700, 16'h4600, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{16'h7BFF, 16'h4600, 1'b0, 1'b1, 1'b0};
        vecs[11] = '{16'h7C00, 16'h4600, 1'b0, 1'b1, 1'b0};
        vecs[12] = '{16'h7E00, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[13] = '{16'hFE01, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[14] = '{16'h7C01, 16'h0000, 1'b1, 1'b0, 1'b1};
        vecs[15] = '{16'h45FF, 16'h45FF, 1'b0, 1'b0, 1'b0};
        vecs[16] = '{16'h83FF, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[17] = '{16'h03FF, 16'h03FF, 1'b0, 1'b0, 1'b0};

        checks   = 0;
        errors   = 0;
        phase    = "reset";
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h4200;
        cur_exp  = '{1'b1, 16'h4200, 1'b0, 1'b0, 1'b0};
        chk_en   = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        rst   = 1'b0;
        phase = "post_reset";
        drive(1'b1, 16'h4200, '{1'b1, 16'h4200, 1'b0, 1'b0, 1'b0});

        phase = "table";
        for (int i = 0; i < 18; i++) begin
            e = '{1'b1, vecs[i].dout, vecs[i].lo, vecs[i].hi, vecs[i].nan};
            drive(1'b1, vecs[i].din, e);
        end

        phase = "gap_seq";
        drive(1'b1, 16'h4700, '{1'b1, 16'h4600, 1'b0, 1'b1, 1'b0});
        drive(1'b0, 16'hBC00, '{1'b0, 16'h0000, 1'b1, 1'b0, 1'b0});
        drive(1'b0, 16'h3C00, '{1'b0, 16'h3C00, 1'b0, 1'b0, 1'b0});
        drive(1'b1, 16'h7E00, '{1'b1, 16'h0000, 1'b1, 1'b0, 1'b1});
        drive(1'b0, 16'h0000, '{1'b0, 16'h0000, 1'b0, 1'b0, 1'b0});

        phase = "mid_reset";
        drive(1'b1, 16'h4200, '{1'b1, 16'h4200, 1'b0, 1'b0, 1'b0});
        rst = 1'b1;
        drive(1'b1, 16'h4601, '{1'b1, 16'h4600, 1'b0, 1'b1, 1'b0});
        rst = 1'b0;
        drive(1'b1, 16'h3C00, '{1'b1, 16'h3C00, 1'b0, 1'b0, 1'b0});

        phase = "random";
        for (int i = 0; i < 200; i++) begin
            logic        v;
            logic [15:0] x;
            v = 1'($urandom_range(0, 1));
            x = 16'($urandom);
            drive(v, x, ref_model(v, x));
        end

        phase = "flush";
        repeat (3) drive(1'b0, 16'h0000, ref_model(1'b0, 16'h0000));

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
